instr_memory_loadable: RTL and testbench

- Parametrised instruction memory for the LC2K core, replacing the fixed-contents combinational instruction ROM.
- Programs are streamed in at run time through a valid/ready load port; the core fetches through a registered, one-cycle-latency port.
- Addresses beyond the loaded program return the LC2K HALT word and raise an error flag, so a runaway PC halts cleanly instead of reading garbage.
- Sits between the testbench/loader and the fetch stage of the single-cycle and pipelined cores.

---
 rtl/instr_memory_loadable.sv | 133 +++++++++++++
 tb/tb_instr_memory_loadable.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_memory_loadable.sv
`default_nettype none
// ============================================================================
// instr_memory_loadable : run-time loadable LC2K instruction memory, 1-cycle fetch
// Revision 1.0
// ============================================================================
module instr_memory_loadable #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 64,
    parameter int               ADDR_W    = 6,
    parameter logic [WIDTH-1:0] HALT_WORD = 32'd25165824
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [WIDTH-1:0]  fetch_instr,
    output logic              fetch_err,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    prog_len_q, prog_len_d;
    logic               load_done_q, load_done_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic [WIDTH-1:0]   fetch_instr_q, fetch_instr_d;
    logic               fetch_err_q, fetch_err_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               w_accept;
    logic               w_fetch_hit;
    logic [ADDR_W:0]    w_ptr_inc;

    assign load_ready  = (state_q == ST_LOAD) && (wr_ptr_q < c_depth);
    assign w_accept    = load_ready && load_valid && !load_start;
    assign w_ptr_inc   = wr_ptr_q + c_one;
    // Full-width compare: a PC past 2^ADDR_W must not alias into the program.
    assign w_fetch_hit = fetch_addr < 32'(prog_len_q);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        prog_len_d    = prog_len_q;
        load_done_d   = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        fetch_err_d   = fetch_err_q;
        if (load_start) begin
            state_d    = ST_LOAD;
            wr_ptr_d   = '0;
            prog_len_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (w_accept) begin
                        wr_ptr_d = w_ptr_inc;
                        if (load_last || (w_ptr_inc == c_depth)) begin
                            state_d     = ST_RUN;
                            prog_len_d  = w_ptr_inc;
                            load_done_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (fetch_req) begin
                        fetch_valid_d = 1'b1;
                        if (w_fetch_hit) begin
                            fetch_instr_d = mem_q[fetch_addr[ADDR_W-1:0]];
                            fetch_err_d   = 1'b0;
                        end else begin
                            fetch_instr_d = HALT_WORD;
                            fetch_err_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            prog_len_q    <= '0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            prog_len_q    <= prog_len_d;
            load_done_q   <= load_done_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Storage is deliberately not reset; prog_len gates every read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= load_data;
        end
    end

    assign load_done   = load_done_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_err   = fetch_err_q;
    assign prog_len    = prog_len_q;
    assign busy        = (state_q != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_instr_memory_loadable.sv
`default_nettype none
// ============================================================================
// tb_instr_memory_loadable : directed table + randomized checks of instr_memory_loadable
// Revision 1.0
// ============================================================================
module tb_instr_memory_loadable;

    localparam int          WIDTH  = 32;
    localparam int          DEPTH  = 64;
    localparam int          ADDR_W = 6;
    localparam logic [31:0] HALT   = 32'd25165824;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start, load_valid, load_last, load_ready, load_done;
    logic [WIDTH-1:0]  load_data;
    logic              fetch_req, fetch_valid, fetch_err, busy;
    logic [31:0]       fetch_addr;
    logic [WIDTH-1:0]  fetch_instr;
    logic [ADDR_W:0]   prog_len;

    instr_memory_loadable #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_WORD(HALT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_err(fetch_err), .prog_len(prog_len),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_mem [DEPTH];
    int          model_len = 0;
    logic [31:0] exp_last_instr = '0;
    logic        exp_last_err = 1'b0;
    logic [31:0] stim [128];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } fetch_vec_t;
    fetch_vec_t table_v [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference answer for a fetch, straight from the address/length rule.
    task automatic model_fetch(input logic [31:0] addr, output logic [31:0] instr, output logic err);
        if (longint'(addr) < longint'(model_len)) begin
            instr = model_mem[addr[ADDR_W-1:0]];
            err   = 1'b0;
        end else begin
            instr = HALT;
            err   = 1'b1;
        end
    endtask

    task automatic fetch_chk(input logic [31:0] addr);
        logic [31:0] ei;
        logic        ee;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        cyc();
        fetch_req  = 1'b0;
        model_fetch(addr, ei, ee);
        check("fetch_valid", {31'd0, fetch_valid}, 32'd1);
        check("fetch_instr", fetch_instr, ei);
        check("fetch_err", {31'd0, fetch_err}, {31'd0, ee});
        exp_last_instr = ei;
        exp_last_err   = ee;
    endtask

    // Streams stim[0..n-1]; optional 3-cycle valid gap before word gap_at.
    task automatic do_load(input int n, input bit use_last, input int gap_at);
        int acc;
        bit fin;
        int i;
        acc = 0;
        fin = 1'b0;
        i   = 0;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        model_len  = 0;
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_prog_len_cleared", 32'(prog_len), 32'd0);
        while (!fin && i < n) begin
            if (i == gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    load_valid = 1'b0;
                    fetch_req  = 1'b1;
                    fetch_addr = 32'd0;
                    cyc();
                    fetch_req = 1'b0;
                    check("gap_fetch_valid", {31'd0, fetch_valid}, 32'd0);
                    check("gap_busy", {31'd0, busy}, 32'd1);
                end
            end
            load_valid = 1'b1;
            load_data  = stim[i];
            load_last  = use_last && (i == n - 1);
            check("load_ready", {31'd0, load_ready}, 32'd1);
            model_mem[acc] = stim[i];
            acc++;
            fin = load_last || (acc == DEPTH);
            i++;
            cyc();
            load_valid = 1'b0;
            load_last  = 1'b0;
            if (!fin) check("load_done_early", {31'd0, load_done}, 32'd0);
        end
        model_len = acc;
        check("load_done", {31'd0, load_done}, 32'd1);
        check("prog_len", 32'(prog_len), acc);
        check("load_ready_after_done", {31'd0, load_ready}, 32'd0);
        check("busy_run", {31'd0, busy}, 32'd0);
        // Excess words (overflow case) must be refused while in RUN.
        while (i < n) begin
            load_valid = 1'b1;
            load_data  = stim[i];
            check("overflow_ready", {31'd0, load_ready}, 32'd0);
            i++;
            cyc();
            load_valid = 1'b0;
        end
        if (!load_done) begin
            check("load_done_pulse", {31'd0, load_done}, 32'd0);
        end else begin
            cyc();
            check("load_done_pulse", {31'd0, load_done}, 32'd0);
        end
        check("prog_len_hold", 32'(prog_len), acc);
    endtask

    task automatic random_fetch_phase(input int ncyc);
        logic        req;
        logic [31:0] addr;
        logic [31:0] ei;
        logic        ee;
        for (int c = 0; c < ncyc; c++) begin
            req = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       addr = $urandom_range(0, model_len + 2);
                1:       addr = $urandom;
                default: addr = (model_len > 0) ? $urandom_range(0, model_len - 1) : 32'd0;
            endcase
            fetch_req  = req;
            fetch_addr = addr;
            cyc();
            fetch_req = 1'b0;
            check("rnd_fetch_valid", {31'd0, fetch_valid}, {31'd0, req});
            if (req) begin
                model_fetch(addr, ei, ee);
                exp_last_instr = ei;
                exp_last_err   = ee;
            end
            check("rnd_fetch_instr", fetch_instr, exp_last_instr);
            check("rnd_fetch_err", {31'd0, fetch_err}, {31'd0, exp_last_err});
        end
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
        table_v[0] = '{32'd0,          32'd8519687,  1'b0};
        table_v[1] = '{32'd5,          32'd1179649,  1'b0};
        table_v[2] = '{32'd6,          32'd25165824, 1'b0};
        table_v[3] = '{32'd7,          32'd25165824, 1'b1};
        table_v[4] = '{32'hFFFF_FFFF,  32'd25165824, 1'b1};
        table_v[5] = '{32'd1,          32'd22216704, 1'b0};
        table_v[6] = '{32'd64,         32'd25165824, 1'b1};
        table_v[7] = '{32'd3,          32'd29360128, 1'b0};

        @(negedge clk);
        cyc();
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'd0);
        check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        rst_n = 1'b1;
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        check("idle_fetch_ignored", {31'd0, fetch_valid}, 32'd0);
        check("idle_load_ready", {31'd0, load_ready}, 32'd0);

        // Reference 7-word program, then the fixed-answer table.
        stim[0] = 32'd8519687;  stim[1] = 32'd22216704; stim[2] = 32'd16777219;
        stim[3] = 32'd29360128; stim[4] = 32'd29360128; stim[5] = 32'd1179649;
        stim[6] = 32'd25165824;
        do_load(7, 1'b1, -1);
        for (int t = 0; t < 8; t++) begin
            fetch_req  = 1'b1;
            fetch_addr = table_v[t].addr;
            cyc();
            fetch_req = 1'b0;
            check($sformatf("tbl%0d_valid", t), {31'd0, fetch_valid}, 32'd1);
            check($sformatf("tbl%0d_instr", t), fetch_instr, table_v[t].instr);
            check($sformatf("tbl%0d_err", t), {31'd0, fetch_err}, {31'd0, table_v[t].err});
        end
        exp_last_instr = table_v[7].instr;
        exp_last_err   = table_v[7].err;
        // Back-to-back fetches 0,1,2.
        for (int a = 0; a < 3; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = a;
            cyc();
            check("b2b_valid", {31'd0, fetch_valid}, 32'd1);
            check("b2b_instr", fetch_instr, stim[a]);
        end
        fetch_req = 1'b0;
        exp_last_instr = stim[2];
        exp_last_err   = 1'b0;
        cyc();
        check("idle_after_b2b_valid", {31'd0, fetch_valid}, 32'd0);
        check("hold_instr", fetch_instr, stim[2]);

        // Overflow: 70 words, no load_last.
        for (int k = 0; k < 70; k++) stim[k] = $urandom;
        do_load(70, 1'b0, -1);
        fetch_chk(32'd63);
        check("ovf_word63", fetch_instr, stim[63]);
        fetch_chk(32'd64);
        check("ovf_addr64_err", {31'd0, fetch_err}, 32'd1);

        // Back-pressure gap mid-stream.
        for (int k = 0; k < 10; k++) stim[k] = $urandom;
        do_load(10, 1'b1, 4);
        for (int a = 0; a < 11; a++) fetch_chk(a);

        // Reset mid-load after 3 of 7 words.
        for (int k = 0; k < 7; k++) stim[k] = $urandom;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data  = stim[k];
            cyc();
        end
        load_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_prog_len", 32'(prog_len), 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        check("mid_rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("mid_rst_fetch_instr", fetch_instr, 32'd0);
        check("mid_rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("mid_rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("mid_rst_load_done", {31'd0, load_done}, 32'd0);
        cyc();
        rst_n = 1'b1;
        model_len = 0;
        exp_last_instr = '0;
        exp_last_err   = 1'b0;
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        check("post_rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        stim[0] = 32'hA5A5_0001;
        stim[1] = 32'h5A5A_0002;
        do_load(2, 1'b1, -1);
        fetch_chk(32'd0);
        fetch_chk(32'd1);
        fetch_chk(32'd2);

        // Collision of load_start and fetch_req in RUN.
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'd0;
        cyc();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        model_len  = 0;
        check("coll_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("coll_busy", {31'd0, busy}, 32'd1);
        check("coll_prog_len", 32'(prog_len), 32'd0);
        stim[0] = 32'h1234_5678;
        do_load(1, 1'b1, -1);
        fetch_chk(32'd0);
        fetch_chk(32'd1);

        // Randomized loads and fetch traffic against the model.
        for (int r = 0; r < 4; r++) begin
            int len;
            len = $urandom_range(1, DEPTH);
            for (int k = 0; k < len; k++) stim[k] = $urandom;
            do_load(len, 1'b1, (r[0]) ? int'($urandom_range(0, len - 1)) : -1);
            random_fetch_phase(150);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
